mem_responder: RTL and testbench

- Memory-side responder for the CPU's mem_cmd/mem_addr/write_data/read_data bus.
- Decodes commands MNONE = 2'b00, MREAD = 2'b01 and MWRITE = 2'b10 against a 9-bit word address.
- Services a 256x16 data/instruction RAM, an 8-bit switch input port and an 8-bit LED output register.
- Returns read data after a programmable number of clock edges, so CPU wait-state sequencing can be exercised at more than one latency.

---
 rtl/mem_responder.sv | 173 +++++++++++++++++
 tb/tb_mem_responder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the CPU mem_cmd/mem_addr/write_data/read_data
//   bus. It serves a 256x16 RAM, an 8-bit switch input port and an 8-bit LED
//   register. Read data is returned after READ_LAT clock edges, which lets the
//   CPU's wait-state sequencing be exercised at more than one latency.
//
// Parameters
//   READ_LAT   : edges from the first sampled MREAD to valid data (1..7)
//   LED_ADDR   : write-only LED register address
//   SW_ADDR    : read-only switch port address
//
// Ports
//   clk        : clock, all state updates on posedge
//   reset      : asynchronous active-low reset
//   mem_cmd    : bus command (00 none, 01 read, 10 write, 11 illegal)
//   mem_addr   : 9-bit word address
//   write_data : store data, valid while mem_cmd is a write
//   read_data  : registered read data
//   rd_valid   : read_data holds the word for the current read address
//   sw         : switch inputs
//   leds       : LED register
//   bus_err    : sticky error flag (unmapped access or illegal command)
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int unsigned READ_LAT = 1,
    parameter logic [8:0]  LED_ADDR = 9'h100,
    parameter logic [8:0]  SW_ADDR  = 9'h140
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic        rd_valid,
    input  logic [7:0]  sw,
    output logic [7:0]  leds,
    output logic        bus_err
);

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;
    localparam logic [1:0] MILL   = 2'b11;

    localparam logic [2:0] LAT_M1 = 3'(READ_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nxt;
    logic [8:0]  r_req_addr;
    logic [8:0]  w_req_nxt;
    logic        w_load;

    logic [15:0] r_read_data;
    logic [7:0]  r_leds;
    logic        r_bus_err;
    logic [15:0] r_ram [0:255];

    // Address decode
    logic        w_is_read;
    logic        w_is_write;
    logic        w_rd_ram;
    logic        w_rd_sw;
    logic        w_wr_ram;
    logic        w_wr_led;
    logic [15:0] w_rd_word;
    logic        w_err_set;

    assign w_is_read  = (mem_cmd == MREAD);
    assign w_is_write = (mem_cmd == MWRITE);
    assign w_rd_ram   = ~mem_addr[8];
    assign w_rd_sw    = (mem_addr == SW_ADDR);
    assign w_wr_ram   = w_is_write & ~mem_addr[8];
    assign w_wr_led   = w_is_write & (mem_addr == LED_ADDR);

    // Every load happens while mem_addr equals the address being served
    // (same-address hold, or a restart that captures mem_addr), so the data
    // source can be decoded straight from mem_addr. The RAM read is
    // combinational so a write on the previous edge is already visible.
    always_comb begin
        w_rd_word = '0;
        if (w_rd_ram) begin
            w_rd_word = r_ram[mem_addr[7:0]];
        end else if (w_rd_sw) begin
            w_rd_word = {8'h00, sw};
        end
    end

    // Read FSM: next state, counter and request address
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_req_nxt   = r_req_addr;
        w_load      = 1'b0;
        if (w_is_read) begin
            if (r_state == S_IDLE || mem_addr != r_req_addr) begin
                // fresh request or address change: restart the count
                w_req_nxt = mem_addr;
                if (READ_LAT == 1) begin
                    w_state_nxt = S_VALID;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = LAT_M1;
                end
            end else if (r_state == S_WAIT) begin
                if (r_cnt == 3'd1) begin
                    w_state_nxt = S_VALID;
                    w_cnt_nxt   = '0;
                    w_load      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end else begin
                // VALID, same address: reload every edge to track the switches
                w_load = 1'b1;
            end
        end else begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end
    end

    assign w_err_set = (mem_cmd == MILL)
                     | (w_is_write & ~w_wr_ram & ~w_wr_led)
                     | (w_load & ~w_rd_ram & ~w_rd_sw);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_req_addr  <= '0;
            r_read_data <= '0;
            r_leds      <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_req_addr <= w_req_nxt;
            if (w_load) begin
                r_read_data <= w_rd_word;
            end
            if (w_wr_led) begin
                r_leds <= write_data[7:0];
            end
            if (w_err_set) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    // RAM contents survive reset
    always_ff @(posedge clk) begin
        if (w_wr_ram) begin
            r_ram[mem_addr[7:0]] <= write_data;
        end
    end

    assign read_data = r_read_data;
    assign rd_valid  = (r_state == S_VALID);
    assign leds      = r_leds;
    assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//   Drives two mem_responder instances (READ_LAT = 1 and READ_LAT = 3) with
//   the same bus stimulus. Expected read words are queued when a read is
//   issued and popped when each instance is due to present valid data.
// ---------------------------------------------------------------------------
module tb_mem_responder;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;
    localparam logic [1:0] MILL   = 2'b11;
    localparam logic [8:0] LED_A  = 9'h100;
    localparam logic [8:0] SW_A   = 9'h140;

    logic        clk;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [7:0]  sw;

    logic [15:0] rd1, rd3;
    logic        rv1, rv3;
    logic [7:0]  led1, led3;
    logic        be1, be3;

    int unsigned n_checks;
    int unsigned n_errors;

    logic [15:0] q1[$];
    logic [15:0] q3[$];

    mem_responder #(.READ_LAT(1), .LED_ADDR(LED_A), .SW_ADDR(SW_A)) u_lat1 (
        .clk        (clk),
        .reset      (reset),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .read_data  (rd1),
        .rd_valid   (rv1),
        .sw         (sw),
        .leds       (led1),
        .bus_err    (be1)
    );

    mem_responder #(.READ_LAT(3), .LED_ADDR(LED_A), .SW_ADDR(SW_A)) u_lat3 (
        .clk        (clk),
        .reset      (reset),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .read_data  (rd3),
        .rd_valid   (rv3),
        .sw         (sw),
        .leds       (led3),
        .bus_err    (be3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic sb_pop1();
        logic [15:0] e;
        if (q1.size() == 0) begin
            check("L1.sb_empty", 16'd1, 16'd0);
        end else begin
            e = q1.pop_front();
            check("L1.read_data", rd1, e);
        end
    endtask

    task automatic sb_pop3();
        logic [15:0] e;
        if (q3.size() == 0) begin
            check("L3.sb_empty", 16'd1, 16'd0);
        end else begin
            e = q3.pop_front();
            check("L3.read_data", rd3, e);
        end
    endtask

    task automatic check_flags(input string tag, input logic exp_be, input logic [7:0] exp_led);
        check({tag, ".L1.bus_err"}, {15'b0, be1}, {15'b0, exp_be});
        check({tag, ".L3.bus_err"}, {15'b0, be3}, {15'b0, exp_be});
        check({tag, ".L1.leds"}, {8'b0, led1}, {8'b0, exp_led});
        check({tag, ".L3.leds"}, {8'b0, led3}, {8'b0, exp_led});
    endtask

    task automatic bus_write(input logic [8:0] a, input logic [15:0] d);
        mem_cmd    = MWRITE;
        mem_addr   = a;
        write_data = d;
        @(posedge clk); #1;
        mem_cmd    = MNONE;
    endtask

    // Issue a read from a restart point (idle or new address) and hold it
    // for n >= 3 edges; the L1 instance is valid after edge 1, L3 after edge 3.
    task automatic read_hold(input logic [8:0] a, input logic [15:0] exp, input int unsigned n);
        mem_cmd  = MREAD;
        mem_addr = a;
        q1.push_back(exp);
        q3.push_back(exp);
        for (int unsigned i = 1; i <= n; i++) begin
            @(posedge clk); #1;
            check("L1.rd_valid", {15'b0, rv1}, 16'd1);
            check("L3.rd_valid", {15'b0, rv3}, (i >= 3) ? 16'd1 : 16'd0);
            if (i == 1) sb_pop1();
            if (i == 3) sb_pop3();
        end
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b1;
        mem_cmd    = MNONE;
        mem_addr   = '0;
        write_data = '0;
        sw         = '0;
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.L1.read_data", rd1, 16'h0000);
        check("rst.L3.read_data", rd3, 16'h0000);
        check("rst.L1.rd_valid", {15'b0, rv1}, 16'd0);
        check("rst.L3.rd_valid", {15'b0, rv3}, 16'd0);
        check_flags("rst", 1'b0, 8'h00);
        reset = 1'b1;

        // basic write then read
        bus_write(9'h005, 16'hBEEF);
        read_hold(9'h005, 16'hBEEF, 3);
        check_flags("rw", 1'b0, 8'h00);

        // address change while valid restarts the latency count
        bus_write(9'h010, 16'h1234);
        bus_write(9'h011, 16'h5678);
        read_hold(9'h010, 16'h1234, 3);
        read_hold(9'h011, 16'h5678, 4);

        // LED register and switch tracking
        bus_write(LED_A, 16'hA5C3);
        check_flags("led", 1'b0, 8'hC3);
        sw = 8'h5A;
        read_hold(SW_A, 16'h005A, 3);
        sw = 8'h3C;
        q1.push_back(16'h003C);
        q3.push_back(16'h003C);
        @(posedge clk); #1;
        sb_pop1();
        sb_pop3();

        // read then idle: valid drops, data held; read-after-write
        bus_write(9'h020, 16'hCAFE);
        read_hold(9'h020, 16'hCAFE, 3);
        mem_cmd = MNONE;
        @(posedge clk); #1;
        check("idle.L1.rd_valid", {15'b0, rv1}, 16'd0);
        check("idle.L3.rd_valid", {15'b0, rv3}, 16'd0);
        check("idle.L1.read_data", rd1, 16'hCAFE);
        check("idle.L3.read_data", rd3, 16'hCAFE);
        bus_write(9'h020, 16'h0001);
        read_hold(9'h020, 16'h0001, 3);
        check_flags("raw", 1'b0, 8'hC3);

        // write to the read-only switch port is unmapped
        bus_write(SW_A, 16'hFFFF);
        check_flags("wrsw", 1'b1, 8'hC3);

        // reset mid-read (L3 in WAIT), read asserted across release
        reset = 1'b0;
        #1 reset = 1'b1;
        mem_cmd  = MREAD;
        mem_addr = 9'h010;
        @(posedge clk); #1;
        check("wait.L3.rd_valid", {15'b0, rv3}, 16'd0);
        check("wait.L1.read_data", rd1, 16'h1234);
        reset = 1'b0;
        #1;
        check("mid.L1.read_data", rd1, 16'h0000);
        check("mid.L3.read_data", rd3, 16'h0000);
        check("mid.L1.rd_valid", {15'b0, rv1}, 16'd0);
        check("mid.L3.rd_valid", {15'b0, rv3}, 16'd0);
        check_flags("mid", 1'b0, 8'h00);
        mem_addr = 9'h005;
        @(posedge clk); #1;
        reset = 1'b1;
        read_hold(9'h005, 16'hBEEF, 3);

        // unmapped read sets the sticky error
        read_hold(9'h1FF, 16'h0000, 3);
        check_flags("unm", 1'b1, 8'h00);
        read_hold(LED_A, 16'h0000, 3);
        bus_write(9'h030, 16'h7777);
        read_hold(9'h030, 16'h7777, 3);
        check_flags("sticky", 1'b1, 8'h00);

        // illegal command from reset: error set, RAM untouched
        reset = 1'b0;
        #1 reset = 1'b1;
        check_flags("rst2", 1'b0, 8'h00);
        mem_cmd    = MILL;
        mem_addr   = 9'h005;
        write_data = 16'h0000;
        @(posedge clk); #1;
        mem_cmd = MNONE;
        check("ill.L1.rd_valid", {15'b0, rv1}, 16'd0);
        check_flags("ill", 1'b1, 8'h00);
        read_hold(9'h005, 16'hBEEF, 3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
